// File: rtl/serial_right_shifter.sv
// serial_right_shifter
// Multi-cycle right shifter: logical shift right, arithmetic shift right and
// rotate right. Each clock applies one binary stage (a shift by 2^k when bit k
// of the shift amount is set), so the latency is always SHAMT_W cycles.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand valid
//   in_ready   unit can accept an operand (IDLE only)
//   in_data    operand
//   in_shamt   shift amount
//   in_mode    0 SRL, 1 SRA, 2 ROR, 3 reserved (runs as SRL)
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts the result
//   out_data   result; holds its last value until the next result
//   busy       high in SHIFT or DONE
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for an operand, in_ready=1
// SHIFT | one binary stage per clock, stage counter r_k = 0..SHAMT_W-1
// DONE  | result presented on out_data, waiting for out_ready
module serial_right_shifter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_SRL = 2'd0;
  localparam logic [1:0] MODE_SRA = 2'd1;
  localparam logic [1:0] MODE_ROR = 2'd2;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_data;
  logic [WIDTH-1:0]   r_out_data;
  logic [WIDTH-1:0]   w_stage;
  logic [SHAMT_W-1:0] r_shamt;
  logic [SHAMT_W-1:0] r_k;
  logic [1:0]         r_mode;
  logic [SHAMT_W:0]   w_amt;
  logic [SHAMT_W:0]   w_ramt;
  logic               w_accept;
  logic               w_last;

  // Stage shift distance 2^k; at most WIDTH/2, so WIDTH-amt never underflows.
  assign w_amt  = (SHAMT_W+1)'(1) << r_k;
  assign w_ramt = (SHAMT_W+1)'(WIDTH) - w_amt;
  assign w_last = (r_k == SHAMT_W'(SHAMT_W-1));

  always_comb begin
    w_stage = r_data;
    if (r_shamt[r_k]) begin
      case (r_mode)
        MODE_SRA: w_stage = $signed(r_data) >>> w_amt;
        MODE_ROR: w_stage = (r_data >> w_amt) | (r_data << w_ramt);
        default:  w_stage = r_data >> w_amt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    w_accept  = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data     <= '0;
      r_out_data <= '0;
      r_shamt    <= '0;
      r_mode     <= MODE_SRL;
      r_k        <= '0;
    end else if (w_accept) begin
      r_data  <= in_data;
      r_shamt <= in_shamt;
      r_mode  <= (in_mode == 2'd3) ? MODE_SRL : in_mode;
      r_k     <= '0;
    end else if (r_state == S_SHIFT) begin
      r_data <= w_stage;
      r_k    <= r_k + SHAMT_W'(1);
      // Separate output register so out_data survives the next accept.
      if (w_last) r_out_data <= w_stage;
    end
  end

  assign out_data = r_out_data;

endmodule

// File: doc/serial_right_shifter.md
Name: serial_right_shifter

Overview:
- Multi-cycle right-direction shift unit: logical shift right, arithmetic shift right and rotate right.
- Companion to the existing combinational left shifter/rotator in the arithmetic library.
- Processes one binary shift stage per clock, trading latency for area, and sits beside the ALU for SRL/SRA/ROR-type operations.
- Operands enter and results leave through valid/ready handshakes.

Parameters:
- WIDTH, 32, data width in bits; must be a power of two, 2..64.
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  unit can accept an operand.
- in_data  input  WIDTH  operand.
- in_shamt  input  SHAMT_W  shift amount.
- in_mode  input  2  0 = SRL, 1 = SRA, 2 = ROR, 3 = reserved (executes as SRL).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  result.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low, on rst_n.
  - Reset forces state IDLE, out_valid=0, out_data=0, busy=0, in_ready=1, stage counter=0, and clears the internal data/shamt/mode registers.
  - Reset asserted mid-operation aborts the operation; no result is ever presented for it.
- State machine:
  - IDLE: in_ready=1. When in_valid && in_ready at an edge, capture in_data, in_shamt and in_mode (mode 3 is stored as 0), clear the stage counter k, and go to SHIFT.
  - SHIFT: in_ready=0, busy=1. At each edge, if shamt[k]=1 the data register shifts right by 2^k; otherwise it holds. Then k increments.
  - SHIFT, fill rules for each stage: SRL fills zeros; SRA fills copies of the current bit WIDTH-1; ROR fills the low 2^k bits being shifted out.
  - SHIFT exit: at the edge that processes k = SHAMT_W-1, go to DONE.
  - DONE: out_valid=1, and out_data holds the final register value. When out_valid && out_ready at an edge, go to IDLE and drop out_valid. out_data keeps its last value.
- Latency:
  - Fixed, independent of shamt (shamt=0 included).
  - Operand accepted at edge N gives out_valid=1 after edge N+SHAMT_W (5 cycles at the default).
  - Minimum spacing between accepts is SHAMT_W+2 cycles: DONE->IDLE needs one edge, and in_ready is never high in DONE.
- Handshake rules:
  - in_valid while in_ready=0 is ignored, with no queuing.
  - out_data and out_valid stay stable while out_valid=1 and out_ready=0, for unbounded backpressure.
  - out_ready while out_valid=0 has no effect.
  - in_data, in_shamt and in_mode may change freely after acceptance; only the captured copies are used.
- Arithmetic:
  - SRA with shamt=WIDTH-1 yields all sign bits.
  - ROR by 0 returns the operand unchanged.
  - No overflow or saturation exists, since shamt cannot exceed WIDTH-1.

Test Plan:
- SRA, in_data=0x80000000, shamt=31 -> out_data=0xFFFFFFFF, out_valid rises exactly 5 edges after accept.
- SRL, in_data=0x80000000, shamt=31 -> 0x00000001; mode 3, in_data=0xF0000000, shamt=4 -> 0x0F000000.
- ROR, in_data=0x0000000F, shamt=4 -> 0xF0000000; ROR, 0x12345678, shamt=8 -> 0x78123456.
- shamt=0, in_data=0x12345678, each of the modes 0, 1, 2 -> 0x12345678, still 5-cycle latency.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while driving in_valid=1 -> out_data stable, in_ready=0, no new accept. Then out_ready=1 -> IDLE next edge, and the next operand is accepted at the following edge.
- Reset during SHIFT at k=2 (SRA 0x80000000, shamt=31) -> out_valid=0, out_data=0, in_ready=1 immediately. After release, SRL 0x00000100, shamt=8 -> 0x00000001.
